// File: rtl/canny_frame_sequencer.sv
// Frame sequencer ahead of the Canny pipeline: forwards one frame of pixels with
// per-row interrupts and FIFO throttling, then injects flush rows to drain the line buffers.
module canny_frame_sequencer #(
  parameter int          IMG_WIDTH   = 512,
  parameter int          IMG_HEIGHT  = 512,
  parameter int          FLUSH_ROWS  = 8,
  parameter logic [7:0]  FLUSH_VALUE = 8'd0,
  localparam int         CW          = $clog2(IMG_HEIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [7:0]    m_data,
  input  logic          fifo_full,
  output logic          row_intr,
  output logic          frame_done,
  output logic          busy,
  output logic [CW-1:0] row_count
);

  localparam int COL_W       = $clog2(IMG_WIDTH);
  localparam int ROW_W       = $clog2(IMG_HEIGHT);
  localparam int FLUSH_TOTAL = FLUSH_ROWS * IMG_WIDTH;
  localparam int FL_W        = (FLUSH_TOTAL > 0) ? $clog2(FLUSH_TOTAL + 1) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_TOTAL - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t           state_reg;
  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic [FL_W-1:0]  flush_reg;
  logic [CW-1:0]    row_count_reg;
  logic             m_valid_reg;
  logic [7:0]       m_data_reg;
  logic             row_intr_reg;
  logic             frame_done_reg;
  logic             busy_reg;
  logic             xfer;

  // Abort masks ready in the same cycle so no pixel is accepted from an abandoned frame.
  assign s_ready = (state_reg == RUN) && !fifo_full && !abort;
  assign xfer    = s_valid && s_ready;

  assign m_valid    = m_valid_reg;
  assign m_data     = m_data_reg;
  assign row_intr   = row_intr_reg;
  assign frame_done = frame_done_reg;
  assign busy       = busy_reg;
  assign row_count  = row_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      col_reg        <= '0;
      row_reg        <= '0;
      flush_reg      <= '0;
      row_count_reg  <= '0;
      m_valid_reg    <= 1'b0;
      m_data_reg     <= 8'd0;
      row_intr_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      m_valid_reg    <= 1'b0;
      row_intr_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      if (abort && state_reg != IDLE) begin
        state_reg     <= IDLE;
        busy_reg      <= 1'b0;
        col_reg       <= '0;
        row_reg       <= '0;
        flush_reg     <= '0;
        row_count_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start && !abort) begin
              state_reg     <= RUN;
              busy_reg      <= 1'b1;
              col_reg       <= '0;
              row_reg       <= '0;
              flush_reg     <= '0;
              row_count_reg <= '0;
            end
          end
          RUN: begin
            if (xfer) begin
              m_valid_reg <= 1'b1;
              m_data_reg  <= s_data;
              if (col_reg == COL_LAST) begin
                col_reg       <= '0;
                row_count_reg <= row_count_reg + CW'(1);
                if (row_reg == ROW_LAST) begin
                  // The last row raises no interrupt; completion is signalled by frame_done.
                  if (FLUSH_TOTAL == 0) begin
                    state_reg      <= DONE;
                    frame_done_reg <= 1'b1;
                  end else begin
                    state_reg <= FLUSH;
                  end
                end else begin
                  row_reg      <= row_reg + ROW_W'(1);
                  row_intr_reg <= 1'b1;
                end
              end else begin
                col_reg <= col_reg + COL_W'(1);
              end
            end
          end
          FLUSH: begin
            if (!fifo_full) begin
              m_valid_reg <= 1'b1;
              m_data_reg  <= FLUSH_VALUE;
              flush_reg   <= flush_reg + FL_W'(1);
              if (flush_reg == FL_LAST) begin
                state_reg      <= DONE;
                frame_done_reg <= 1'b1;
              end
            end
          end
          DONE: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_canny_frame_sequencer.sv
// Randomized bench for canny_frame_sequencer; a count-based frame model predicts every
// output cycle by cycle and the full output stream per frame.
module tb_canny_frame_sequencer;

  localparam int         W  = 4;
  localparam int         H  = 3;
  localparam int         F  = 2;
  localparam logic [7:0] FV = 8'd0;
  localparam int         CW = $clog2(H + 1);

  logic          clk, rst, start, abort, s_valid, fifo_full;
  logic [7:0]    s_data;
  logic          s_ready, m_valid, row_intr, frame_done, busy;
  logic [7:0]    m_data;
  logic [CW-1:0] row_count;

  canny_frame_sequencer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .FLUSH_ROWS(F), .FLUSH_VALUE(FV)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .fifo_full(fifo_full),
    .row_intr(row_intr), .frame_done(frame_done), .busy(busy), .row_count(row_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Frame model: a frame is "active" from start until one cycle after completion;
  // progress is just the number of accepted pixels and emitted flush beats.
  bit         active, in_done;
  int         accepted, flushed, rc;
  bit         e_mvalid, e_rowintr, e_done, e_busy;
  logic [7:0] e_mdata;
  int         base;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         done_seen;

  task automatic model_step(input bit st, input bit ab, input bit take, input logic [7:0] d,
                            input bit ff, input bit rs);
    e_mvalid  = 1'b0;
    e_rowintr = 1'b0;
    e_done    = 1'b0;
    if (rs) begin
      active = 0; in_done = 0; accepted = 0; flushed = 0; rc = 0; e_mdata = 8'd0;
    end else if (!active) begin
      if (st && !ab) begin
        active = 1; in_done = 0; accepted = 0; flushed = 0; rc = 0;
      end
    end else if (ab) begin
      active = 0; in_done = 0; accepted = 0; flushed = 0; rc = 0;
    end else if (in_done) begin
      active = 0; in_done = 0;
    end else if (accepted < W * H) begin
      if (take) begin
        e_mvalid = 1'b1;
        e_mdata  = d;
        accepted++;
        rc = accepted / W;
        if (accepted % W == 0 && accepted < W * H) e_rowintr = 1'b1;
        if (accepted == W * H && F * W == 0) begin in_done = 1; e_done = 1'b1; end
      end
    end else if (!ff) begin
      e_mvalid = 1'b1;
      e_mdata  = FV;
      flushed++;
      if (flushed == F * W) begin in_done = 1; e_done = 1'b1; end
    end
    e_busy = active;
    if (e_mvalid) exp_q.push_back(e_mdata);
  endtask

  task automatic cycle(input bit st, input bit ab, input bit sv, input bit ff, input bit rs);
    logic [7:0] d;
    bit         exp_sready;
    d = 8'(base + accepted + 1);
    start = st; abort = ab; s_valid = sv; s_data = d; fifo_full = ff; rst = rs;
    #1;
    exp_sready = active && !in_done && (accepted < W * H) && !ff && !ab;
    check("s_ready", 32'(s_ready), 32'(exp_sready));
    model_step(st, ab, sv && exp_sready, d, ff, rs);
    @(posedge clk);
    #1;
    check("m_valid", 32'(m_valid), 32'(e_mvalid));
    if (e_mvalid || rs) check("m_data", 32'(m_data), 32'(e_mdata));
    check("row_intr", 32'(row_intr), 32'(e_rowintr));
    check("frame_done", 32'(frame_done), 32'(e_done));
    check("busy", 32'(busy), 32'(e_busy));
    check("row_count", 32'(row_count), 32'(rc));
    if (m_valid) obs_q.push_back(m_data);
    if (frame_done) done_seen++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit sv);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, sv, 1'b0, 1'b0);
  endtask

  int frame_no = 0;

  task automatic run_frame(input int sv_pct, input int ff_pct, input int ff_run_at,
                           input int ff_flush_at, input int abort_at, input int rst_at,
                           input bit noise, input int b);
    int  ff_left, cyc;
    bit  run_used, flush_used, ab_used, rs_used, st, ab, rs, ff, sv, cut;
    base = b;
    exp_q.delete(); obs_q.delete();
    done_seen = 0; ff_left = 0; cyc = 0; cut = 0;
    run_used = 0; flush_used = 0; ab_used = 0; rs_used = 0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    while (active && cyc < 400) begin
      cyc++;
      st = noise && (in_done || $urandom_range(0, 3) == 0);
      ab = 1'b0;
      rs = 1'b0;
      if (abort_at >= 0 && !ab_used && accepted == abort_at) begin ab = 1'b1; ab_used = 1; cut = 1; end
      if (rst_at >= 0 && !rs_used && accepted == W * H && flushed == rst_at && !in_done) begin
        rs = 1'b1; rs_used = 1; cut = 1;
      end
      if (ff_run_at >= 0 && !run_used && accepted == ff_run_at) begin run_used = 1; ff_left = 5; end
      if (ff_flush_at >= 0 && !flush_used && accepted == W * H && flushed == ff_flush_at) begin
        flush_used = 1; ff_left = 3;
      end
      ff = (ff_left > 0) ? 1'b1 : ($urandom_range(0, 99) < ff_pct);
      if (ff_left > 0) ff_left--;
      sv = ($urandom_range(0, 99) < sv_pct);
      cycle(st, ab, sv, ff, rs);
    end
    if (active) check("frame_timeout", 32'd1, 32'd0);
    if (!cut) begin
      check("frame_done_count", 32'(done_seen), 32'd1);
      check("beat_count", 32'(obs_q.size()), 32'(W * H + F * W));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
        check($sformatf("beat%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
    end else begin
      check("cut_frame_done", 32'(done_seen), 32'd0);
    end
    $display("frame %0d: beats=%0d done=%0d cut=%0d cycles=%0d", frame_no, obs_q.size(),
             done_seen, cut, cyc);
    frame_no++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'd0; fifo_full = 1'b0;
    active = 0; in_done = 0; accepted = 0; flushed = 0; rc = 0; base = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);

    run_frame(100, 0, -1, -1, -1, -1, 1'b0, 0);      // plain frame, pixels 1..12
    run_frame(100, 0, 5, -1, -1, -1, 1'b0, 20);      // fifo_full held mid-row 2
    run_frame(100, 0, -1, 2, -1, -1, 1'b0, 40);      // fifo_full during flush
    run_frame(100, 0, -1, -1, 6, -1, 1'b0, 60);      // abort after pixel 6
    idle(3, 1'b1);
    run_frame(100, 0, -1, -1, -1, -1, 1'b0, 0);      // full replay after abort
    run_frame(70, 20, -1, -1, -1, -1, 1'b1, 80);     // start noise during RUN/FLUSH/DONE
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);             // start+abort in IDLE
    idle(3, 1'b1);
    run_frame(100, 0, -1, -1, -1, 3, 1'b0, 100);     // rst during flush
    idle(4, 1'b1);
    for (int k = 0; k < 6; k++) begin
      run_frame($urandom_range(40, 100), $urandom_range(0, 40), -1, -1,
                ($urandom_range(0, 2) == 0) ? $urandom_range(0, W * H - 1) : -1,
                -1, 1'b1, $urandom_range(0, 255));
      idle(2, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
